// File: rtl/mc_ctrl_fsm.sv
// Main sequencing controller for the multicycle ARM32 datapath.
// One state register. All datapath enables and mux selects are combinational
// from the current state and the decoder/memory inputs. Architectural writes
// are gated by the condition check. A write to R15 is steered to the PC flop.
module mc_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic               cond_ex,
  input  logic               pcs,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               adr_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               alu_op,
  output logic [1:0]         result_src,
  output logic               mem_write,
  output logic               reg_write,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXECR  = STATE_W'(6),
    EXECI  = STATE_W'(7),
    ALUWB  = STATE_W'(8),
    BRANCH = STATE_W'(9)
  } state_t;

  state_t state_q, state_d;

  // Raw (ungated) strobes produced by the state decode.
  logic next_pc;
  logic branch;
  logic regw;
  logic memw;

  // While reset is held the memory handshake is ignored, so FETCH does not
  // raise ir_write or pc_write before the machine is running.
  logic mem_ready_eff;
  assign mem_ready_eff = mem_ready & reset_n;

  // Only funct[5] (immediate) and funct[0] (load/store) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and per-state datapath controls.
  always_comb begin
    state_d    = FETCH;
    next_pc    = 1'b0;
    branch     = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 1'b0;
    result_src = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      FETCH: begin
        adr_src    = 1'b0;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 1'b0;
        result_src = 2'b10;
        ir_write   = mem_ready_eff;
        next_pc    = mem_ready_eff;
        state_d    = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_op     = 1'b0;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? EXECI : EXECR;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        alu_op    = 1'b0;
        state_d   = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        state_d    = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        result_src = 2'b01;
        regw       = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        // The store strobe stays high through wait cycles until memory accepts.
        adr_src    = 1'b1;
        result_src = 2'b00;
        memw       = 1'b1;
        state_d    = mem_ready ? FETCH : MEMWR;
      end
      EXECR: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        alu_op    = 1'b1;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        state_d   = ALUWB;
      end
      ALUWB: begin
        result_src = 2'b00;
        regw       = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b01;
        alu_op     = 1'b0;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Condition gating: a failed condition walks the sequence with no writes.
  // A register write aimed at R15 becomes a PC write instead.
  assign reg_write = regw & cond_ex & ~pcs;
  assign mem_write = memw & cond_ex;
  assign pc_write  = next_pc | (branch & cond_ex) | (regw & cond_ex & pcs);
  assign state_o   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed per-cycle vectors with hand-derived
// expected controls, checked by a scoreboard monitor on the falling edge.
module tb_mc_ctrl_fsm;

  logic       clk;
  logic       reset_n;
  logic [1:0] op;
  logic [5:0] funct;
  logic       cond_ex;
  logic       pcs;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       alu_op;
  logic [1:0] result_src;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .funct      (funct),
    .cond_ex    (cond_ex),
    .pcs        (pcs),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .adr_src    (adr_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .result_src (result_src),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .illegal    (illegal),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs a hand-written control vector: {state, pcw, irw, adr, asa, asb, aop, rs, mw, rw, ill}.
  function automatic logic [15:0] ev(input logic [3:0] st, input logic pcw, input logic irw,
                                     input logic adr, input logic asa, input logic [1:0] asb,
                                     input logic aop, input logic [1:0] rs, input logic mw,
                                     input logic rw, input logic ill);
    return {st, pcw, irw, adr, asa, asb, aop, rs, mw, rw, ill};
  endfunction

  function automatic logic [15:0] act_vec();
    return {state_o, pc_write, ir_write, adr_src, alu_src_a, alu_src_b, alu_op,
            result_src, mem_write, reg_write, illegal};
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, queue the
  // controls expected during that cycle.
  task automatic cyc(input string nm, input logic [1:0] o, input logic [5:0] f,
                     input logic c, input logic p, input logic mr, input logic [15:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    op = o; funct = f; cond_ex = c; pcs = p; mem_ready = mr;
    e.name = nm;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // FETCH with memory ready followed by DECODE of a legal op.
  task automatic fd(input string nm, input logic [1:0] o, input logic [5:0] f,
                    input logic c, input logic p);
    cyc({nm, "_fetch"},  o, f, c, p, 1'b1, ev(4'd0, 1, 1, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0));
    cyc({nm, "_decode"}, o, f, c, p, 1'b1, ev(4'd1, 0, 0, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0));
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, act_vec(), e.exp);
      end
    end
  end

  initial begin
    reset_n = 1'b0; op = 2'b00; funct = 6'd0; cond_ex = 1'b1; pcs = 1'b0; mem_ready = 1'b1;
    #3;
    // In reset: FETCH controls with mem_ready ignored.
    chk("reset_vec", act_vec(), ev(4'd0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0));
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD R1 register form: 0,1,6,8
    fd("add", 2'b00, 6'b000000, 1, 0);
    cyc("add_execr", 2'b00, 6'b000000, 1, 0, 1, ev(4'd6, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0));
    cyc("add_aluwb", 2'b00, 6'b000000, 1, 0, 1, ev(4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));

    // Immediate form: 0,1,7,8
    fd("addi", 2'b00, 6'b100000, 1, 0);
    cyc("addi_execi", 2'b00, 6'b100000, 1, 0, 1, ev(4'd7, 0, 0, 0, 0, 2'b01, 1, 2'b00, 0, 0, 0));
    cyc("addi_aluwb", 2'b00, 6'b100000, 1, 0, 1, ev(4'd8, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 1, 0));

    // LDR with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    fd("ldr", 2'b01, 6'b011001, 1, 0);
    cyc("ldr_memadr", 2'b01, 6'b011001, 1, 0, 1, ev(4'd2, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
    cyc("ldr_memrd0", 2'b01, 6'b011001, 1, 0, 0, ev(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0));
    cyc("ldr_memrd1", 2'b01, 6'b011001, 1, 0, 0, ev(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0));
    cyc("ldr_memrd2", 2'b01, 6'b011001, 1, 0, 1, ev(4'd3, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0));
    cyc("ldr_memwb",  2'b01, 6'b011001, 1, 0, 1, ev(4'd4, 0, 0, 0, 0, 2'b00, 0, 2'b01, 0, 1, 0));

    // STR with failed condition: 0,1,2,5, no mem_write
    fd("strnc", 2'b01, 6'b011000, 0, 0);
    cyc("strnc_memadr", 2'b01, 6'b011000, 0, 0, 1, ev(4'd2, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
    cyc("strnc_memwr",  2'b01, 6'b011000, 0, 0, 1, ev(4'd5, 0, 0, 1, 0, 2'b00, 0, 2'b00, 0, 0, 0));

    // STR with one wait cycle: mem_write in both MEMWR cycles
    fd("str", 2'b01, 6'b011000, 1, 0);
    cyc("str_memadr", 2'b01, 6'b011000, 1, 0, 1, ev(4'd2, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
    cyc("str_memwr0", 2'b01, 6'b011000, 1, 0, 0, ev(4'd5, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 0, 0));
    cyc("str_memwr1", 2'b01, 6'b011000, 1, 0, 1, ev(4'd5, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 0, 0));

    // Branch taken, then not taken
    fd("b", 2'b10, 6'b000000, 1, 0);
    cyc("b_branch", 2'b10, 6'b000000, 1, 0, 1, ev(4'd9, 1, 0, 0, 0, 2'b01, 0, 2'b10, 0, 0, 0));
    fd("bnc", 2'b10, 6'b000000, 0, 0);
    cyc("bnc_branch", 2'b10, 6'b000000, 0, 0, 1, ev(4'd9, 0, 0, 0, 0, 2'b01, 0, 2'b10, 0, 0, 0));

    // Data-processing into R15: write steered to PC
    fd("pcs", 2'b00, 6'b000000, 1, 1);
    cyc("pcs_execr", 2'b00, 6'b000000, 1, 1, 1, ev(4'd6, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 0, 0));
    cyc("pcs_aluwb", 2'b00, 6'b000000, 1, 1, 1, ev(4'd8, 1, 0, 0, 0, 2'b00, 0, 2'b00, 0, 0, 0));

    // Undefined op: illegal pulse in DECODE, back to FETCH
    cyc("ill_fetch",  2'b11, 6'b000000, 1, 0, 1, ev(4'd0, 1, 1, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0));
    cyc("ill_decode", 2'b11, 6'b000000, 1, 0, 1, ev(4'd1, 0, 0, 0, 1, 2'b10, 0, 2'b10, 0, 0, 1));

    // FETCH parked on mem_ready low
    cyc("park_fetch0", 2'b00, 6'b000000, 1, 0, 0, ev(4'd0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0));
    cyc("park_fetch1", 2'b00, 6'b000000, 1, 0, 0, ev(4'd0, 0, 0, 0, 1, 2'b10, 0, 2'b10, 0, 0, 0));

    // Store stalled in MEMWR, then asynchronous reset between edges
    fd("rst", 2'b01, 6'b011000, 1, 0);
    cyc("rst_memadr", 2'b01, 6'b011000, 1, 0, 1, ev(4'd2, 0, 0, 0, 0, 2'b01, 0, 2'b00, 0, 0, 0));
    cyc("rst_memwr",  2'b01, 6'b011000, 1, 0, 0, ev(4'd5, 0, 0, 1, 0, 2'b00, 0, 2'b00, 1, 0, 0));
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", {12'd0, state_o}, 16'd0);
    chk("async_memw", {15'd0, mem_write}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // FETCH resumes after release
    fd("post", 2'b00, 6'b000000, 1, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", sb_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main sequencing controller for the multicycle ARM32 datapath.
- Drives the enables and mux selects of the architectural registers: PC flop, instruction register, data register and register file write port. It also drives the ALU/result muxes.
- Sits between the instruction decoder (op/funct fields, condition check) and the datapath.
- Inserts wait states on a simple memory-ready handshake.

Parameters:
- STATE_W, 4, width of state encoding and state_o.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- op  input  2  instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
- funct  input  6  instr[25:20]; funct[5]=I (immediate), funct[0]=S/L (load when op=01).
- cond_ex  input  1  condition check passed for current instruction (from cond unit).
- pcs  input  1  current instruction writes R15 (Rd==15 with register write).
- mem_ready  input  1  memory completes the current access this cycle.
- pc_write  output  1  enable for PC flop.
- ir_write  output  1  enable for instruction register.
- adr_src  output  1  memory address select: 0 PC, 1 ALU result.
- alu_src_a  output  1  0 register A, 1 PC.
- alu_src_b  output  2  00 register B, 01 extended immediate, 10 constant 4.
- alu_op  output  1  0 force ADD, 1 decode funct.
- result_src  output  2  00 ALUOut, 01 data register, 10 ALU result direct.
- mem_write  output  1  memory write strobe.
- reg_write  output  1  register file write enable.
- illegal  output  1  one-cycle pulse on undefined op decode.
- state_o  output  STATE_W  current state for debug/trace.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 are unused.
- Reset: reset_n low forces state=FETCH asynchronously. All outputs take their FETCH values with mem_ready treated as 0: pc_write=0, ir_write=0, mem_write=0, reg_write=0, illegal=0, alu_src_a=1, alu_src_b=10, result_src=10, adr_src=0, alu_op=0.
- The state register is the only flop. Outputs are combinational from state plus inputs.

Transitions (evaluated at each rising edge):
- FETCH -> DECODE when mem_ready=1; otherwise stay in FETCH.
- DECODE -> MEMADR if op=01; EXECI if op=00 and funct[5]=1; EXECR if op=00 and funct[5]=0; BRANCH if op=10; FETCH if op=11 (illegal=1 that cycle).
- MEMADR -> MEMRD if funct[0]=1, else MEMWR.
- MEMRD -> MEMWB when mem_ready=1; otherwise stay in MEMRD.
- MEMWR -> FETCH when mem_ready=1; otherwise stay in MEMWR.
- EXECR and EXECI -> ALUWB.
- MEMWB, ALUWB and BRANCH -> FETCH.
- Unused codes -> FETCH.

Per-state outputs (any unlisted signal is 0 or don't-care, driven as 0):
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, alu_op=0, result_src=10. ir_write=mem_ready. Raw next_pc=mem_ready.
- DECODE: alu_src_a=1, alu_src_b=10, alu_op=0, result_src=10.
- MEMADR: alu_src_a=0, alu_src_b=01, alu_op=0.
- MEMRD: adr_src=1, result_src=00.
- MEMWB: result_src=01, raw regw=1.
- MEMWR: adr_src=1, result_src=00. Raw memw=1 for every cycle spent in MEMWR, including wait cycles.
- EXECR: alu_src_a=0, alu_src_b=00, alu_op=1.
- EXECI: alu_src_a=0, alu_src_b=01, alu_op=1.
- ALUWB: result_src=00, raw regw=1.
- BRANCH: alu_src_a=0, alu_src_b=01, alu_op=0, result_src=10, raw branch=1.

Gating:
- reg_write = regw & cond_ex & ~pcs.
- mem_write = memw & cond_ex.
- pc_write = next_pc | (branch & cond_ex) | (regw & cond_ex & pcs).

Failed conditions and timing:
- A failed condition (cond_ex=0) still walks the full state sequence with no architectural write.
- Latency: R/I ALU ops take 4 cycles, loads 5 cycles (+ wait states), stores 4 cycles (+ wait states), branches 3 cycles.
- Undefined op takes 2 cycles and still advances PC by 4, since the FETCH update has already occurred.

Boundaries:
- mem_ready held low leaves the FSM parked indefinitely with stable outputs.
- Reset asserted mid-store drops mem_write immediately (asynchronous).
- On reset release the FSM starts in FETCH on the next edge.

Test Plan:
- Reset, then ADD R1 (op=00, funct=000000, cond_ex=1, mem_ready=1) -> state_o sequence 0,1,6,8,0; reg_write=1 only in state 8; pc_write=1 only in first FETCH.
- LDR (op=01, funct=011001), mem_ready low for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0; adr_src=1 in 3; reg_write=1 in 4 with result_src=01.
- STR (op=01, funct=011000), cond_ex=0 -> sequence 0,1,2,5,0; mem_write=0 throughout. Rerun with cond_ex=1 and mem_ready low for 1 cycle -> mem_write=1 for both MEMWR cycles.
- B (op=10), cond_ex=1 then cond_ex=0 -> sequence 0,1,9,0; pc_write=1 in state 9 only when cond_ex=1.
- Data-processing with pcs=1, cond_ex=1 -> ALUWB gives reg_write=0, pc_write=1. op=11 -> illegal=1 in DECODE, next state 0.
- Assert reset_n=0 asynchronously mid-MEMWR (mem_ready=0) -> state_o=0 and mem_write=0 before the next clock edge. FETCH resumes after release.
